// File: rtl/uwasic_onboarding_spi_pwm_if.sv
// Tile pin bundle (ena, ui/uio inputs and uo/uio outputs) shared by the
// onboarding tile and its harness; the harness drives the master side.
interface uwasic_onboarding_spi_pwm_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/uwasic_onboarding_spi_pwm.sv
// Onboarding tile: write-only SPI (mode 0) loads five control registers that
// drive 16 outputs low/high/PWM. Define SPI_SYNC_EN for multi-flop pin synchronizers.
//
// state    | meaning
// S_IDLE   | waiting for a sampled nCS falling edge
// S_SHIFT  | nCS low, shifting COPI on SCLK rising edges
// S_COMMIT | valid frame seen, write data byte to addressed register
module uwasic_onboarding_spi_pwm #(
  parameter int PWM_PRESCALE = 13,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  uwasic_onboarding_spi_pwm_if.slave pins
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PWM_PRESCALE - 1);

  state_t      state_q, state_d;
  logic [2:0]  spi_s;
  logic        sclk_prev_q, ncs_prev_q;
  logic        sclk_rise, ncs_fall, ncs_rise;
  logic [15:0] shreg_q;
  logic [4:0]  cnt_q;
  logic        clr_frame, shift_en, wr_en, frame_ok;
  logic [15:0] en_out_q, en_pwm_q, out_q;
  logic [7:0]  duty_q, pwm_cnt_q;
  logic [PW-1:0] pre_q;
  logic        pwm;
  logic        unused_pins;

  // Sync flops reset to 0 so a low nCS held through reset never looks like a new frame start.
`ifdef SPI_SYNC_EN
  logic [2:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pins.ui_in[2:0];
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign spi_s = sync_q[SYNC_STAGES-1];
`else
  localparam int unused_sync_stages = SYNC_STAGES;
  logic [2:0] samp_q;

  always_ff @(posedge clk) begin
    if (rst) samp_q <= '0;
    else     samp_q <= pins.ui_in[2:0];
  end

  assign spi_s = samp_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
    end else begin
      sclk_prev_q <= spi_s[0];
      ncs_prev_q  <= spi_s[2];
    end
  end

  assign sclk_rise = spi_s[0] & ~sclk_prev_q;
  assign ncs_fall  = ~spi_s[2] & ncs_prev_q;
  assign ncs_rise  = spi_s[2] & ~ncs_prev_q;
  assign frame_ok  = (cnt_q == 5'd16) && shreg_q[15] && (shreg_q[14:8] <= 7'h04);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clr_frame = 1'b0;
    shift_en  = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ncs_fall) begin
          clr_frame = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ncs_rise)       state_d  = frame_ok ? S_COMMIT : S_IDLE;
        else if (sclk_rise) shift_en = 1'b1;
      end
      S_COMMIT: begin
        wr_en   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit counter saturates at 17 so over-long frames stay distinguishable from 16.
  always_ff @(posedge clk) begin
    if (rst || clr_frame) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shreg_q <= {shreg_q[14:0], spi_s[1]};
      if (cnt_q != 5'd17) cnt_q <= cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_out_q <= '0;
      en_pwm_q <= '0;
      duty_q   <= '0;
    end else if (wr_en) begin
      case (shreg_q[14:8])
        7'h00:   en_out_q[7:0]  <= shreg_q[7:0];
        7'h01:   en_out_q[15:8] <= shreg_q[7:0];
        7'h02:   en_pwm_q[7:0]  <= shreg_q[7:0];
        7'h03:   en_pwm_q[15:8] <= shreg_q[7:0];
        7'h04:   duty_q         <= shreg_q[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      pwm_cnt_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q     <= '0;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  // 0xFF is forced fully high so the top duty code is a true constant-on.
  assign pwm = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= en_out_q & (~en_pwm_q | {16{pwm}});
  end

  assign pins.uo_out  = out_q[7:0];
  assign pins.uio_out = out_q[15:8];
  assign pins.uio_oe  = 8'hFF;

  assign unused_pins = ^{pins.ena, pins.uio_in, pins.ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_spi_pwm.sv
// Scoreboard bench for the onboarding SPI/PWM tile: stimulus queues expected
// per-bit high-cycle counts over windows, a monitor process measures and compares.
module tb_uwasic_onboarding_spi_pwm;
  localparam int PERIOD = 3328;
  localparam int PRESCALE = 13;

  typedef struct {
    string             name;
    int                start;
    int                len;
    logic [15:0]       mask;
    logic [15:0]       phase;
    logic [15:0][12:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_busy = 1'b0;
  int   last_rise = 0;
  chk_t sb[$];

  logic [15:0] m_eo = '0;
  logic [15:0] m_ep = '0;
  logic [7:0]  m_duty = '0;

  uwasic_onboarding_spi_pwm_if pins();

  uwasic_onboarding_spi_pwm dut (
    .clk  (clk),
    .rst  (rst),
    .pins (pins)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_outputs(input string name, input int start, input int len,
                                input logic [15:0] phase);
    chk_t e;
    int hi;
    e.name = name; e.start = start; e.len = len; e.phase = phase;
    e.mask = '1; e.exp = '0;
    hi = (m_duty == 8'hFF) ? len : int'(m_duty) * PRESCALE * (len / PERIOD);
    for (int b = 0; b < 16; b++) begin
      if (m_eo[b]) begin
        if (!m_ep[b]) e.exp[b] = 13'(len);
        else if ((len % PERIOD) == 0 || m_duty == 8'h00 || m_duty == 8'hFF) e.exp[b] = 13'(hi);
        else e.mask[b] = 1'b0;
      end
    end
    sb.push_back(e);
  endtask

  task automatic spi_bit(input logic b);
    pins.ui_in[1] = b;
    repeat (3) @(negedge clk);
    pins.ui_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    pins.ui_in[0] = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] bits, input int n);
    pins.ui_in[2] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) spi_bit(bits[i]);
    repeat (3) @(negedge clk);
    pins.ui_in[2] = 1'b1;
    last_rise = cyc;
    if (n == 16 && bits[15] && bits[14:8] <= 7'h04) begin
      case (bits[10:8])
        3'd0: m_eo[7:0]  = bits[7:0];
        3'd1: m_eo[15:8] = bits[7:0];
        3'd2: m_ep[7:0]  = bits[7:0];
        3'd3: m_ep[15:8] = bits[7:0];
        default: m_duty  = bits[7:0];
      endcase
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || mon_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d checks still pending after %0d cycles, expected 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  initial begin : monitor
    chk_t e;
    int cnt[16];
    int perr, oerr, bad;
    logic [15:0] v;
    forever begin
      @(negedge clk);
      if (sb.size() != 0 && cyc >= sb[0].start) begin
        e = sb.pop_front();
        mon_busy = 1'b1;
        for (int b = 0; b < 16; b++) cnt[b] = 0;
        perr = 0; oerr = 0;
        for (int k = 0; k < e.len; k++) begin
          if (k != 0) @(negedge clk);
          v = {pins.uio_out, pins.uo_out};
          for (int b = 0; b < 16; b++) if (v[b]) cnt[b]++;
          if ((v & e.phase) != 16'h0 && (v & e.phase) != e.phase) perr++;
          if (pins.uio_oe != 8'hFF) oerr++;
        end
        n_checks++;
        bad = -1;
        for (int b = 0; b < 16; b++)
          if (bad < 0 && e.mask[b] && cnt[b] != int'(e.exp[b])) bad = b;
        if (bad >= 0) begin
          n_fail++;
          $display("FAIL %s: out bit %0d high %0d of %0d cycles, expected %0d (phase errs %0d, oe errs %0d)",
                   e.name, bad, cnt[bad], e.len, e.exp[bad], perr, oerr);
        end else if (perr != 0 || oerr != 0) begin
          n_fail++;
          $display("FAIL %s: phase errs %0d, oe errs %0d, expected 0 and 0", e.name, perr, oerr);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] inv_bits [5];
    int          inv_n    [5];
    string       inv_name [5];
    logic [15:0] f;
    inv_bits = '{32'h0000B0AA, 32'h000000FF, 32'h00008512, 32'h00000080, 32'h000080AA};
    inv_n    = '{16, 16, 16, 8, 17};
    inv_name = '{"write addr 0x30", "read frame", "write addr 0x05", "8-bit frame", "17-bit frame"};

    pins.ena = 1'b1;
    pins.uio_in = 8'h00;
    pins.ui_in = 8'b0000_0100;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_outputs("reset", cyc + 1, 1, 16'h0);
    drain(100);

    spi_frame(32'h80F0, 16);
    expect_outputs("write reg0", last_rise + 6, 1, 16'h0);
    drain(100);
    spi_frame(32'h81CC, 16);
    expect_outputs("write reg1", last_rise + 6, 1, 16'h0);
    drain(100);

    for (int i = 0; i < 5; i++) begin
      spi_frame(inv_bits[i], inv_n[i]);
      expect_outputs(inv_name[i], last_rise + 8, 1, 16'h0);
      drain(100);
    end

    pins.ui_in[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat (3) @(negedge clk);
      pins.ui_in[0] = 1'b1;
      repeat (3) @(negedge clk);
      pins.ui_in[0] = 1'b0;
    end
    expect_outputs("sclk while ncs high", cyc + 8, 1, 16'h0);
    drain(100);

    spi_frame(32'h80F1, 16);
    spi_frame(32'h8201, 16);
    spi_frame(32'h8480, 16);
    expect_outputs("duty 0x80 one period", last_rise + 20, PERIOD, 16'h0);
    drain(2 * PERIOD);

    spi_frame(32'h8400, 16);
    expect_outputs("duty 0x00", last_rise + 10, PERIOD, 16'h0);
    drain(2 * PERIOD);

    spi_frame(32'h84FF, 16);
    expect_outputs("duty 0xFF two periods", last_rise + 10, 2 * PERIOD, 16'h0);
    drain(3 * PERIOD);

    spi_frame(32'h81FF, 16);
    spi_frame(32'h830F, 16);
    spi_frame(32'h8440, 16);
    expect_outputs("upper pwm duty 0x40", last_rise + 20, PERIOD, 16'h0F01);
    drain(2 * PERIOD);

    f = 16'h8055;
    pins.ui_in[2] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 15; i >= 6; i--) spi_bit(f[i]);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_eo = '0; m_ep = '0; m_duty = '0;
    expect_outputs("reset mid-frame", cyc + 1, 1, 16'h0);
    drain(100);
    for (int i = 5; i >= 0; i--) spi_bit(f[i]);
    repeat (3) @(negedge clk);
    pins.ui_in[2] = 1'b1;
    expect_outputs("aborted frame tail", cyc + 8, 1, 16'h0);
    drain(100);

    spi_frame(32'h8055, 16);
    expect_outputs("write reg0 after reset", last_rise + 6, 1, 16'h0);
    drain(100);
    spi_frame(32'h80FF, 16);
    expect_outputs("en_pwm cleared by reset", last_rise + 10, PERIOD, 16'h0);
    drain(2 * PERIOD);
    spi_frame(32'h82FF, 16);
    expect_outputs("duty cleared by reset", last_rise + 10, PERIOD, 16'h0);
    drain(2 * PERIOD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
